// File: rtl/pwl_sigmoid_pkg.sv
// Shared definitions for the 5-segment PWL sigmoid and its inverse search.
// Breakpoints, slopes and intercepts live here so the forward curve and the
// logit search always evaluate the identical function.
//   - segment boundaries (Q8.8): -640, -256, 256, 640
//   - slopes (Q0.8 multipliers): 33 outer segments, 59 centre segment
//   - intercepts (Q8.8): 101, 128, 155
//   - state_t: control states of the iterative search
package pwl_sigmoid_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic signed [DATA_W-1:0] BND_LO     = -16'sd640;
    localparam logic signed [DATA_W-1:0] BND_MID_LO = -16'sd256;
    localparam logic signed [DATA_W-1:0] BND_MID_HI = 16'sd256;
    localparam logic signed [DATA_W-1:0] BND_HI     = 16'sd640;

    localparam logic signed [DATA_W-1:0] SLOPE_OUTER = 16'sd33;
    localparam logic signed [DATA_W-1:0] SLOPE_MID   = 16'sd59;

    localparam logic signed [DATA_W-1:0] ICPT_LO  = 16'sd101;
    localparam logic signed [DATA_W-1:0] ICPT_MID = 16'sd128;
    localparam logic signed [DATA_W-1:0] ICPT_HI  = 16'sd155;

    // Saturation levels of the curve outside [BND_LO, BND_HI).
    localparam logic signed [DATA_W-1:0] F_SAT_LO = 16'sd0;
    localparam logic signed [DATA_W-1:0] F_SAT_HI = 16'sd256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/pwl_sigmoid_eval.sv
// Combinational 5-segment PWL sigmoid f(x).
// Ports:
//   x : in  16b signed Q8.8 argument
//   f : out 16b signed Q8.8 probability in [0,256]
// Each linear segment is ((x*slope) >>> 8) + intercept with a 32b signed
// product; the shift is a floor, matching the forward sigmoid bit-exactly.
module pwl_sigmoid_eval
    import pwl_sigmoid_pkg::*;
(
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] f
);

    logic signed [DATA_W-1:0] slope;
    logic signed [DATA_W-1:0] icpt;
    logic signed [31:0]       prod;
    logic                     sat_lo;
    logic                     sat_hi;

    always_comb begin
        slope  = SLOPE_MID;
        icpt   = ICPT_MID;
        sat_lo = 1'b0;
        sat_hi = 1'b0;
        if (x < BND_LO) begin
            sat_lo = 1'b1;
        end else if (x < BND_MID_LO) begin
            slope = SLOPE_OUTER;
            icpt  = ICPT_LO;
        end else if (x < BND_MID_HI) begin
            slope = SLOPE_MID;
            icpt  = ICPT_MID;
        end else if (x < BND_HI) begin
            slope = SLOPE_OUTER;
            icpt  = ICPT_HI;
        end else begin
            sat_hi = 1'b1;
        end
    end

    // Both operands are sign-extended to the 32b context before multiplying.
    assign prod = x * slope;

    always_comb begin
        if (sat_lo) begin
            f = F_SAT_LO;
        end else if (sat_hi) begin
            f = F_SAT_HI;
        end else begin
            f = 16'(prod >>> 8) + icpt;
        end
    end

endmodule

// File: rtl/pwl_logit_search.sv
// Inverse PWL sigmoid: for a Q8.8 probability y, finds the smallest Q8.8 x in
// [X_MIN, X_MAX] with f(x) >= y by bisection, one step per clock.
// Ports:
//   clk       : in  clock, rising edge
//   rst       : in  synchronous reset, active-high
//   in_valid  : in  y_in valid
//   in_ready  : out idle, request can be accepted
//   y_in      : in  16b signed Q8.8 probability (clamped to [0,256])
//   out_valid : out x_out valid
//   out_ready : in  downstream accepts x_out
//   x_out     : out 16b signed Q8.8 logit estimate
//   busy      : out high in SEARCH or DONE
// Latency from accept edge to out_valid is fixed at ITER+1 edges: ITER
// bisection steps followed by one edge that publishes hi to x_out.
module pwl_logit_search
    import pwl_sigmoid_pkg::*;
#(
    parameter int X_MIN = -640,
    parameter int X_MAX = 640,
    parameter int ITER  = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] x_out,
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(ITER + 1);

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] lo_q, lo_d;
    logic signed [DATA_W-1:0] hi_q, hi_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic [CNT_W-1:0]         step_cnt_q, step_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] x_out_q, x_out_d;

    logic signed [DATA_W:0]   mid_sum;
    logic signed [DATA_W-1:0] mid;
    logic signed [DATA_W-1:0] f_mid;
    logic signed [DATA_W-1:0] y_clamped;

    // 17-bit sum so lo+hi cannot overflow before the arithmetic halving.
    assign mid_sum = {lo_q[DATA_W-1], lo_q} + {hi_q[DATA_W-1], hi_q};
    assign mid     = 16'(mid_sum >>> 1);

    pwl_sigmoid_eval u_eval (
        .x (mid),
        .f (f_mid)
    );

    always_comb begin
        if (y_in < F_SAT_LO) begin
            y_clamped = F_SAT_LO;
        end else if (y_in > F_SAT_HI) begin
            y_clamped = F_SAT_HI;
        end else begin
            y_clamped = y_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        y_d         = y_q;
        step_cnt_d  = step_cnt_q;
        out_valid_d = out_valid_q;
        x_out_d     = x_out_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d        = y_clamped;
                    lo_d       = 16'(X_MIN);
                    hi_d       = 16'(X_MAX);
                    step_cnt_d = '0;
                    state_d    = SEARCH;
                end
            end
            SEARCH: begin
                if (step_cnt_q == CNT_W'(ITER)) begin
                    x_out_d     = hi_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    // f(hi) >= y is invariant; once lo==hi, hi stays put.
                    if (f_mid >= y_q) begin
                        hi_d = mid;
                    end else begin
                        lo_d = mid + 16'sd1;
                    end
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            y_q         <= '0;
            step_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            y_q         <= y_d;
            step_cnt_q  <= step_cnt_d;
            out_valid_q <= out_valid_d;
            x_out_q     <= x_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;

endmodule

// File: tb/tb_pwl_logit_search.sv
module tb_pwl_logit_search;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] y_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] x_out;
    logic               busy;

    int vectors;
    int miscompares;

    pwl_logit_search #(
        .X_MIN (-640),
        .X_MAX (640),
        .ITER  (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference curve in plain integer arithmetic with an explicit floor.
    function automatic int floor_div256(int p);
        int q;
        q = p / 256;
        if ((p % 256 != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int f_ref(int x);
        if (x < -640) return 0;
        if (x < -256) return floor_div256(x * 33) + 101;
        if (x < 256)  return floor_div256(x * 59) + 128;
        if (x < 640)  return floor_div256(x * 33) + 155;
        return 256;
    endfunction

    // Smallest x in range meeting the target, found by exhaustive scan.
    function automatic int x_ref(int y);
        int yc;
        yc = (y < 0) ? 0 : ((y > 256) ? 256 : y);
        for (int x = -640; x <= 640; x++) begin
            if (f_ref(x) >= yc) return x;
        end
        return 640;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; stall = cycles out_ready is held low in DONE,
    // during which in_valid is also asserted to show it is not accepted.
    task automatic run_one(input int y, input int stall, input string tag);
        int  exp_x;
        int  lat;
        bit  got;
        exp_x = x_ref(y);
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        check({tag, "_ready_wait"}, in_ready, 1);
        in_valid  = 1'b1;
        y_in      = 16'(y);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy_acc"}, busy, 1);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                got = 1'b1;
            end
        end
        check({tag, "_latency"}, lat, 12);
        check({tag, "_x"}, x_out, exp_x);
        if (stall > 0) in_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_hold_x"}, x_out, exp_x);
            check({tag, "_hold_v"}, out_valid, 1);
            check({tag, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_hs_v"}, out_valid, 0);
        check({tag, "_hs_busy"}, busy, 0);
        check({tag, "_hs_rdy"}, in_ready, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        int xo;
        int y;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y_in      = '0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_x_out", x_out, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Directed points, including clamp and saturation corners.
        run_one(128, 0, "y128");
        run_one(186, 0, "y186");
        run_one(19, 0, "y19");
        run_one(18, 0, "y18");
        run_one(-5, 0, "yneg");
        run_one(256, 0, "y256");
        run_one(300, 0, "y300");
        run_one(237, 0, "y237");
        run_one(0, 0, "y0");
        run_one(187, 5, "stall");

        // Reset mid-search aborts the transaction.
        in_valid = 1'b1;
        y_in     = 16'sd200;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_x_out", x_out, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (out_valid) seen = 1'b1;
            end
            check("abort_no_valid", seen, 0);
        end
        run_one(128, 0, "post_abort");

        // Random probabilities, including out-of-range values and stalls.
        for (int i = 0; i < 25; i++) begin
            y = int'($urandom_range(1100, 0)) - 400;
            run_one(y, int'($urandom_range(3, 0)), "rand");
        end

        // Exhaustive sweep with a round-trip property check.
        for (int yy = 0; yy <= 256; yy++) begin
            run_one(yy, 0, "sweep");
            xo = int'(x_out);
            check("sweep_ge", (f_ref(xo) >= yy) ? 1 : 0, 1);
            check("sweep_min", ((xo == -640) || (f_ref(xo - 1) < yy)) ? 1 : 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
